int_sequencer: RTL and testbench

INT_SEQUENCER -- requirements
Module: int_sequencer

---
 rtl/int_sequencer_if.sv | 38 +++
 rtl/int_sequencer.sv | 169 ++++++++++++++++
 tb/tb_int_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_sequencer_if.sv
// int_sequencer_if
// Groups the request, pipeline-status and redirect signals of the interrupt
// sequencer so the block and its environment connect through one bundle.
//   in_EN       pipeline advance enable (0 = stalled)
//   in_BUSY     jump/branch redirect in flight, interrupts held off
//   in_IRQ      request lines, bit 2 is highest priority
//   in_ERET     ERET decoded
//   in_PC       resume PC of the oldest uncommitted instruction
//   out_FLUSH   clear IF/ID and ID/EX
//   out_INTJ    load PC from out_VECTOR
//   out_VECTOR  jump target
//   out_EPC     saved PC of the active level (0 when none)
//   out_SERVICE in-service bitmap
//   out_PENDING pending bitmap
// Modport slave is used by the sequencer, master by its driver.
interface int_sequencer_if;
  logic        in_EN;
  logic        in_BUSY;
  logic [2:0]  in_IRQ;
  logic        in_ERET;
  logic [31:0] in_PC;
  logic        out_FLUSH;
  logic        out_INTJ;
  logic [31:0] out_VECTOR;
  logic [31:0] out_EPC;
  logic [2:0]  out_SERVICE;
  logic [2:0]  out_PENDING;

  modport slave (
    input  in_EN, in_BUSY, in_IRQ, in_ERET, in_PC,
    output out_FLUSH, out_INTJ, out_VECTOR, out_EPC, out_SERVICE, out_PENDING
  );

  modport master (
    output in_EN, in_BUSY, in_IRQ, in_ERET, in_PC,
    input  out_FLUSH, out_INTJ, out_VECTOR, out_EPC, out_SERVICE, out_PENDING
  );
endinterface

// File: rtl/int_sequencer.sv
// int_sequencer
// Three-level nested interrupt sequencer. Rising edges on in_IRQ latch into a
// pending bitmap; a pending level above the active one is accepted when the
// pipeline advances and no redirect is in flight. Acceptance saves the resume
// PC for that level, flushes the front of the pipeline for DRAIN enabled
// cycles, then pulses a jump to VEC_BASE + level*16. ERET pops the active
// level and jumps back to its saved PC.
// Ports:
//   in_CLK  clock (rising edge)
//   in_RST  synchronous active-high reset
//   bus     int_sequencer_if.slave carrying all request/status/redirect signals
module int_sequencer #(
  parameter logic [31:0] VEC_BASE = 32'h0000_1000,
  parameter int          DRAIN    = 2
) (
  input logic              in_CLK,
  input logic              in_RST,
  int_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_JUMP  = 2'd2;
  localparam logic [1:0] ST_RET   = 2'd3;

  // Counter preload: the DRAIN-th enabled cycle in the flush state moves on.
  localparam logic [2:0] CNT_INIT = 3'(DRAIN - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  prev_q, prev_d;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  service_q, service_d;
  logic [31:0] epc_q [3];
  logic [31:0] epc_d [3];
  logic [31:0] vector_q, vector_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [1:0]  top_lvl_s;
  logic [2:0]  above_mask_s;
  logic [2:0]  eligible_s;
  logic        cand_valid_s;
  logic [1:0]  cand_lvl_s;
  logic [2:0]  edge_s;
  logic [2:0]  pend_clr_s;

  // Active level and the set of levels allowed to preempt it.
  always_comb begin
    top_lvl_s    = 2'd0;
    above_mask_s = 3'b111;
    if (service_q[2]) begin
      top_lvl_s    = 2'd2;
      above_mask_s = 3'b000;
    end else if (service_q[1]) begin
      top_lvl_s    = 2'd1;
      above_mask_s = 3'b100;
    end else if (service_q[0]) begin
      top_lvl_s    = 2'd0;
      above_mask_s = 3'b110;
    end else begin
      top_lvl_s    = 2'd0;
      above_mask_s = 3'b111;
    end
  end

  // Highest pending level that may preempt the active one.
  always_comb begin
    eligible_s   = pending_q & above_mask_s;
    cand_valid_s = |eligible_s;
    cand_lvl_s   = 2'd0;
    if (eligible_s[2]) begin
      cand_lvl_s = 2'd2;
    end else if (eligible_s[1]) begin
      cand_lvl_s = 2'd1;
    end else begin
      cand_lvl_s = 2'd0;
    end
  end

  // Next-state logic: edge capture, accept/return decisions and drain count.
  always_comb begin
    state_d    = state_q;
    prev_d     = bus.in_IRQ;
    service_d  = service_q;
    vector_d   = vector_q;
    cnt_d      = cnt_q;
    pend_clr_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      epc_d[i] = epc_q[i];
    end
    edge_s = bus.in_IRQ & ~prev_q;

    case (state_q)
      ST_IDLE: begin
        // ERET has priority over a new acceptance; the request stays pending.
        if (bus.in_ERET && (service_q != 3'b000)) begin
          vector_d             = epc_q[top_lvl_s];
          service_d[top_lvl_s] = 1'b0;
          state_d              = ST_RET;
        end else if (bus.in_EN && !bus.in_BUSY && cand_valid_s) begin
          epc_d[cand_lvl_s]      = bus.in_PC;
          service_d[cand_lvl_s]  = 1'b1;
          pend_clr_s[cand_lvl_s] = 1'b1;
          vector_d               = VEC_BASE + {26'd0, cand_lvl_s, 4'd0};
          cnt_d                  = CNT_INIT;
          state_d                = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Only enabled cycles count toward the drain; stalls extend the flush.
        if (bus.in_EN) begin
          if (cnt_q == 3'd0) begin
            state_d = ST_JUMP;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_JUMP: begin
        state_d = ST_IDLE;
      end
      ST_RET: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pending_d = (pending_q | edge_s) & ~pend_clr_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state_q   <= ST_IDLE;
      prev_q    <= 3'b000;
      pending_q <= 3'b000;
      service_q <= 3'b000;
      vector_q  <= 32'd0;
      cnt_q     <= 3'd0;
      for (int i = 0; i < 3; i++) begin
        epc_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      service_q <= service_d;
      vector_q  <= vector_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < 3; i++) begin
        epc_q[i] <= epc_d[i];
      end
    end
  end

  // FLUSH and INTJ are decoded straight from the state register.
  assign bus.out_FLUSH   = (state_q != ST_IDLE);
  assign bus.out_INTJ    = (state_q == ST_JUMP) || (state_q == ST_RET);
  assign bus.out_VECTOR  = vector_q;
  assign bus.out_SERVICE = service_q;
  assign bus.out_PENDING = pending_q;
  assign bus.out_EPC     = (service_q != 3'b000) ? epc_q[top_lvl_s] : 32'd0;

endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer
// Directed bench for int_sequencer: reset, single interrupt, nesting,
// priority blocking, BUSY/EN stalls, ERET-vs-candidate and reset mid-drain.
module tb_int_sequencer;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  int_sequencer_if bus ();

  int_sequencer #(
    .VEC_BASE (32'h0000_1000),
    .DRAIN    (2)
  ) dut (
    .in_CLK (clk),
    .in_RST (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic f, input logic j);
    check({tag, "_flush"}, {31'd0, bus.out_FLUSH}, {31'd0, f});
    check({tag, "_intj"},  {31'd0, bus.out_INTJ},  {31'd0, j});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_EN = 1'b0;
    bus.in_BUSY = 1'b0;
    bus.in_IRQ = 3'b111;
    bus.in_ERET = 1'b0;
    bus.in_PC = 32'd0;

    // Reset with all lines high, then release: held lines register as edges.
    tick();
    tick();
    check_ctl("rst", 1'b0, 1'b0);
    check("rst_vector",  bus.out_VECTOR, 32'd0);
    check("rst_epc",     bus.out_EPC, 32'd0);
    check("rst_service", {29'd0, bus.out_SERVICE}, 32'd0);
    check("rst_pending", {29'd0, bus.out_PENDING}, 32'd0);
    rst = 1'b0;
    tick();
    check("rel_pending", {29'd0, bus.out_PENDING}, 32'd7);
    rst = 1'b1;
    bus.in_IRQ = 3'b000;
    tick();
    rst = 1'b0;
    tick();
    check("clean_pending", {29'd0, bus.out_PENDING}, 32'd0);

    // Single interrupt on line 1.
    bus.in_EN = 1'b1;
    bus.in_PC = 32'h40;
    bus.in_IRQ = 3'b010;
    tick();
    check("s_pending", {29'd0, bus.out_PENDING}, 32'd2);
    check_ctl("s_idle", 1'b0, 1'b0);
    tick();
    check_ctl("s_drain1", 1'b1, 1'b0);
    check("s_service", {29'd0, bus.out_SERVICE}, 32'd2);
    check("s_pend_clr", {29'd0, bus.out_PENDING}, 32'd0);
    check("s_epc", bus.out_EPC, 32'h40);
    check("s_vector", bus.out_VECTOR, 32'h1010);
    tick();
    check_ctl("s_drain2", 1'b1, 1'b0);
    tick();
    check_ctl("s_jump", 1'b1, 1'b1);
    check("s_jvec", bus.out_VECTOR, 32'h1010);
    tick();
    check_ctl("s_back", 1'b0, 1'b0);
    bus.in_ERET = 1'b1;
    tick();
    check_ctl("s_ret", 1'b1, 1'b1);
    check("s_rvec", bus.out_VECTOR, 32'h40);
    check("s_rsvc", {29'd0, bus.out_SERVICE}, 32'd0);
    check("s_repc", bus.out_EPC, 32'd0);
    bus.in_ERET = 1'b0;
    tick();
    check_ctl("s_ridle", 1'b0, 1'b0);

    // Nesting: level 0 active, level 2 preempts, ERET returns to level 0.
    bus.in_IRQ = 3'b001;
    bus.in_PC = 32'h20;
    tick();
    tick();
    check("n_svc0", {29'd0, bus.out_SERVICE}, 32'd1);
    check("n_vec0", bus.out_VECTOR, 32'h1000);
    tick();
    tick();
    check_ctl("n_jump0", 1'b1, 1'b1);
    tick();
    bus.in_IRQ = 3'b101;
    bus.in_PC = 32'h80;
    tick();
    check("n_pend2", {29'd0, bus.out_PENDING}, 32'd4);
    tick();
    check("n_svc2", {29'd0, bus.out_SERVICE}, 32'd5);
    check("n_vec2", bus.out_VECTOR, 32'h1020);
    check("n_epc2", bus.out_EPC, 32'h80);
    tick();
    tick();
    check_ctl("n_jump2", 1'b1, 1'b1);
    tick();
    bus.in_ERET = 1'b1;
    tick();
    check_ctl("n_ret", 1'b1, 1'b1);
    check("n_rvec", bus.out_VECTOR, 32'h80);
    check("n_rsvc", {29'd0, bus.out_SERVICE}, 32'd1);
    check("n_repc", bus.out_EPC, 32'h20);
    bus.in_ERET = 1'b0;
    tick();
    bus.in_ERET = 1'b1;
    tick();
    check("n_ret0vec", bus.out_VECTOR, 32'h20);
    check("n_ret0svc", {29'd0, bus.out_SERVICE}, 32'd0);
    bus.in_ERET = 1'b0;
    tick();

    // Priority block: level 2 active, level 0 must wait for ERET.
    bus.in_IRQ = 3'b000;
    tick();
    bus.in_IRQ = 3'b100;
    bus.in_PC = 32'h100;
    tick();
    tick();
    tick();
    tick();
    tick();
    check("p_svc", {29'd0, bus.out_SERVICE}, 32'd4);
    bus.in_IRQ = 3'b101;
    tick();
    check("p_pend", {29'd0, bus.out_PENDING}, 32'd1);
    tick();
    check_ctl("p_blocked", 1'b0, 1'b0);
    check("p_pend_held", {29'd0, bus.out_PENDING}, 32'd1);
    bus.in_ERET = 1'b1;
    tick();
    check_ctl("p_ret", 1'b1, 1'b1);
    check("p_rvec", bus.out_VECTOR, 32'h100);
    bus.in_ERET = 1'b0;
    tick();
    check_ctl("p_idle", 1'b0, 1'b0);
    tick();
    check_ctl("p_take", 1'b1, 1'b0);
    check("p_vec0", bus.out_VECTOR, 32'h1000);
    check("p_svc0", {29'd0, bus.out_SERVICE}, 32'd1);
    tick();
    tick();
    tick();
    bus.in_ERET = 1'b1;
    tick();
    bus.in_ERET = 1'b0;
    tick();
    check("p_clean", {29'd0, bus.out_SERVICE}, 32'd0);

    // BUSY holds off acceptance; EN low in DRAIN stretches the flush.
    bus.in_IRQ = 3'b000;
    tick();
    bus.in_BUSY = 1'b1;
    bus.in_IRQ = 3'b010;
    bus.in_PC = 32'h200;
    tick();
    tick();
    check_ctl("b_busy", 1'b0, 1'b0);
    check("b_pend", {29'd0, bus.out_PENDING}, 32'd2);
    bus.in_BUSY = 1'b0;
    tick();
    check_ctl("b_accept", 1'b1, 1'b0);
    bus.in_EN = 1'b0;
    tick();
    check_ctl("e_stall1", 1'b1, 1'b0);
    tick();
    check_ctl("e_stall2", 1'b1, 1'b0);
    tick();
    check_ctl("e_stall3", 1'b1, 1'b0);
    bus.in_EN = 1'b1;
    tick();
    check_ctl("e_drain", 1'b1, 1'b0);
    tick();
    check_ctl("e_jump", 1'b1, 1'b1);
    tick();

    // ERET coinciding with a pending candidate: return first.
    bus.in_IRQ = 3'b110;
    tick();
    check("c_pend", {29'd0, bus.out_PENDING}, 32'd4);
    bus.in_ERET = 1'b1;
    tick();
    check_ctl("c_ret", 1'b1, 1'b1);
    check("c_rvec", bus.out_VECTOR, 32'h200);
    check("c_pend_kept", {29'd0, bus.out_PENDING}, 32'd4);
    bus.in_ERET = 1'b0;
    tick();
    tick();
    check_ctl("c_take", 1'b1, 1'b0);
    check("c_vec", bus.out_VECTOR, 32'h1020);

    // Reset in the middle of DRAIN.
    rst = 1'b1;
    tick();
    check_ctl("r_mid", 1'b0, 1'b0);
    check("r_vec", bus.out_VECTOR, 32'd0);
    check("r_svc", {29'd0, bus.out_SERVICE}, 32'd0);
    check("r_epc", bus.out_EPC, 32'd0);
    bus.in_IRQ = 3'b000;
    rst = 1'b0;
    tick();
    check_ctl("r_after1", 1'b0, 1'b0);
    tick();
    check_ctl("r_after2", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
